pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush generator for the 4-buffer pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives the hold and flush inputs of every pipeline buffer and the PC hold.
//  Detects load-use hazards and taken branches, and sequences multi-cycle mul/div stalls.
//  Keeps a saturating stall-cycle counter for debug.
// PARAMETERS
//  RA_W       4   register-address width
//  MD_CYCLES  8   EX occupancy of a mul/div op in cycles, >=2
//  CNT_W      16  stall counter width
// PORTS
//  clock          in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-low
//  id_rs1         in   RA_W   source reg 1 of the instruction in IF/ID
//  id_rs2         in   RA_W   source reg 2 of the instruction in IF/ID
//  id_rs1_used    in   1      rs1 is a real operand
//  id_rs2_used    in   1      rs2 is a real operand
//  ex_memread     in   1      instruction in ID/EX is a load
//  ex_rd          in   RA_W   destination of the instruction in ID/EX
//  ex_branch_tkn  in   1      branch/jump in EX resolved taken (redirect this cycle)
//  ex_md_start    in   1      mul/div op entering EX this cycle
//  pc_hold        out  1      freeze PC
//  ifid_hold      out  1      hold for the IF/ID buffer
//  idex_hold      out  1      hold for the ID/EX buffer
//  exmem_hold     out  1      hold for the EX/MEM buffer
//  ifid_flush     out  1      flush for the IF/ID buffer
//  idex_flush     out  1      flush for the ID/EX buffer
//  exmem_flush    out  1      flush for the EX/MEM buffer
//  md_busy        out  1      mul/div in progress
//  md_done        out  1      1-cycle pulse on the final mul/div cycle
//  stall_cnt      out  CNT_W  cycles with pc_hold=1, saturating
// BEHAVIOUR
//  - Reset: state=RUN, md counter=0, stall_cnt=0; while reset=0 all outputs are 0.
//  - Outputs are combinational from the registered state and the current inputs.
//    They act on the same rising edge (zero latency).
//  - FSM states: RUN and MD_WAIT.
//  - RUN -> MD_WAIT on ex_md_start; md counter loads MD_CYCLES-2.
//  - MD_WAIT: counter decrements each cycle. At 0: md_done=1, next state=RUN.
//    The op therefore spends exactly MD_CYCLES cycles in EX.
//  - MD stall (ex_md_start in RUN, or any MD_WAIT cycle except the md_done cycle):
//    pc_hold=ifid_hold=idex_hold=1; exmem_flush=1 (bubble into MEM).
//    All other inputs are ignored.
//  - md_busy=1 in MD_WAIT and in the RUN cycle that has ex_md_start.
//  - Load-use, RUN only: ex_memread and ex_rd!=0, and either
//    (id_rs1_used & id_rs1==ex_rd) or (id_rs2_used & id_rs2==ex_rd).
//    Response: pc_hold=ifid_hold=1 and idex_flush=1 for 1 cycle. Self-clears when the load advances.
//  - Branch taken, RUN, no md stall: ifid_flush=idex_flush=1, no holds.
//    Overrides load-use (the dependent instruction is squashed).
//  - Priority: reset > md stall > branch > load-use > none.
//  - Register 0 never causes a hazard.
//  - hold and flush are never asserted together on the same buffer.
//  - stall_cnt increments on every edge where pc_hold=1 and holds at all-ones (no wrap).
//  - Reset mid-MD_WAIT: asynchronous return to RUN, counter cleared, no md_done pulse.
//  - ex_md_start while in MD_WAIT: ignored (the EX stage is held).
// STRUCTURE
//  - Shared package/include: state encodings ST_RUN/ST_MD_WAIT, MD_CYCLES default, RA_W.
//    The same RA_W is used by the decoder and the register file.
//  - One natural sub-module, hazard_detect: purely combinational load-use comparator.
//    The FSM, md counter and stall counter live in the top module.
// TESTING
//  1 Load-use: ex_memread=1, ex_rd=3, id_rs1=3, rs1_used=1
//    -> pc_hold=ifid_hold=idex_flush=1 for exactly 1 cycle; stall_cnt 0->1.
//  2 ex_rd=0 with id_rs1=0, ex_memread=1 -> no hold, no flush.
//  3 ex_branch_tkn=1 together with a load-use match
//    -> ifid_flush=idex_flush=1, pc_hold=0, ifid_hold=0.
//  4 ex_md_start pulse, MD_CYCLES=8 -> holds + exmem_flush for 7 cycles.
//    md_done high in cycle 8 with holds low; stall_cnt +=7.
//  5 reset=0 during cycle 3 of MD_WAIT -> all outputs 0 immediately.
//    After release: RUN, no md_done pulse.
//  6 Force stall_cnt to all-ones, apply a further stall -> stays all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// RA_W is the register-address width used by the decoder and register file.
package pipeline_hazard_ctrl_pkg;

    localparam int RA_W      = 4;
    localparam int MD_CYCLES = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the
// instruction in ID actually reads. Register 0 never matches.
module hazard_detect #(
    parameter int RA_W = pipeline_hazard_ctrl_pkg::RA_W
) (
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rd,
    output logic            load_use
);
    import pipeline_hazard_ctrl_pkg::*;

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rd_live  = ex_memread && (ex_rd != '0);
        rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
        rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
        load_use = rd_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the IF/ID, ID/EX, EX/MEM buffers and the PC.
// Handles load-use, taken branches and multi-cycle mul/div occupancy.
module pipeline_hazard_ctrl #(
    parameter int RA_W      = pipeline_hazard_ctrl_pkg::RA_W,
    parameter int MD_CYCLES = pipeline_hazard_ctrl_pkg::MD_CYCLES,
    parameter int CNT_W     = pipeline_hazard_ctrl_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_branch_tkn,
    input  logic             ex_md_start,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int MDC_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES - 1) : 1;

    state_t             state_q, state_d;
    logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic in_run;
    logic md_stall;
    logic md_last;
    logic br_act;
    logic lu_act;

    hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (ex_md_start) begin
                    state_d  = ST_MD_WAIT;
                    md_cnt_d = MDC_W'(MD_CYCLES - 2);
                end
            end
            ST_MD_WAIT: begin
                if (md_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Mutually exclusive selectors so the decoder below stays one-hot.
    always_comb begin
        in_run   = (state_q == ST_RUN);
        md_last  = reset && !in_run && (md_cnt_q == '0);
        md_stall = reset && ((in_run && ex_md_start) ||
                             (!in_run && (md_cnt_q != '0)));
        br_act   = reset && in_run && !ex_md_start && ex_branch_tkn;
        lu_act   = reset && in_run && !ex_md_start && !ex_branch_tkn &&
                   load_use;
    end

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = reset && (!in_run || ex_md_start);
        md_done     = md_last;
        unique case (1'b1)
            md_stall: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_hold   = 1'b1;
                exmem_flush = 1'b1;
            end
            br_act: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            lu_act: begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch, mul/div,
// asynchronous reset mid-op and stall counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int RA_W  = 4;
    localparam int CNT_W = 8;

    // ctl = {pc, ifid_h, idex_h, exmem_h, ifid_f, idex_f, exmem_f, busy, done}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_LU   = 9'b110001000;
    localparam logic [8:0] C_BR   = 9'b000011000;
    localparam logic [8:0] C_MD   = 9'b111000110;
    localparam logic [8:0] C_DONE = 9'b000000011;

    logic             clock = 1'b0;
    logic             reset;
    logic [RA_W-1:0]  id_rs1, id_rs2, ex_rd;
    logic             id_rs1_used, id_rs2_used;
    logic             ex_memread, ex_branch_tkn, ex_md_start;
    logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic             md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       ctl;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.RA_W(RA_W), .MD_CYCLES(8), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .ex_branch_tkn (ex_branch_tkn),
        .ex_md_start   (ex_md_start),
        .pc_hold       (pc_hold),
        .ifid_hold     (ifid_hold),
        .idex_hold     (idex_hold),
        .exmem_hold    (exmem_hold),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .stall_cnt     (stall_cnt)
    );

    assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                  ifid_flush, idex_flush, exmem_flush, md_busy, md_done};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_memread = 1'b0; ex_branch_tkn = 1'b0; ex_md_start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        // Hazard-looking inputs while in reset must not leak through.
        ex_md_start = 1'b1; ex_branch_tkn = 1'b1; ex_memread = 1'b1;
        ex_rd = 4'd3; id_rs1 = 4'd3; id_rs1_used = 1'b1;
        #3;
        chk("rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("rst_cnt", 32'(stall_cnt), 0);
        clear_in();
        @(negedge clock);
        reset = 1'b1;
        step();

        // Load-use on rs1, one cycle, then the load advances.
        ex_memread = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_rs1_used = 1'b1;
        @(negedge clock);
        chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        chk("lu_rs1_cnt0", 32'(stall_cnt), 0);
        step();
        ex_memread = 1'b0;
        @(negedge clock);
        chk("lu_rs1_clear", 32'(ctl), 32'(C_NONE));
        chk("lu_rs1_cnt1", 32'(stall_cnt), 1);
        step();

        // Load-use via rs2 only, then same with rs2 not a real operand.
        ex_memread = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_rs2_used = 1'b1;
        @(negedge clock);
        chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
        step();
        id_rs2_used = 1'b0;
        @(negedge clock);
        chk("lu_rs2_unused", 32'(ctl), 32'(C_NONE));
        chk("lu_rs2_cnt", 32'(stall_cnt), 2);
        step();

        // Register 0 never hazards.
        clear_in();
        ex_memread = 1'b1; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        @(negedge clock);
        chk("x0_ctl", 32'(ctl), 32'(C_NONE));
        step();

        // Branch overrides load-use; branch alone.
        ex_rd = 4'd3; id_rs1 = 4'd3; ex_branch_tkn = 1'b1;
        @(negedge clock);
        chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
        step();
        ex_memread = 1'b0;
        @(negedge clock);
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        chk("br_cnt", 32'(stall_cnt), 2);
        step();
        clear_in();

        // Mul/div: 7 stall cycles, done in cycle 8; other inputs ignored.
        ex_md_start = 1'b1;
        @(negedge clock);
        chk("md_c1", 32'(ctl), 32'(C_MD));
        step();
        ex_branch_tkn = 1'b1; ex_memread = 1'b1;
        ex_rd = 4'd3; id_rs1 = 4'd3; id_rs1_used = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            @(negedge clock);
            chk($sformatf("md_c%0d", i), 32'(ctl), 32'(C_MD));
            step();
        end
        @(negedge clock);
        chk("md_done", 32'(ctl), 32'(C_DONE));
        chk("md_cnt", 32'(stall_cnt), 9);
        step();
        clear_in();
        @(negedge clock);
        chk("md_after", 32'(ctl), 32'(C_NONE));
        step();

        // Asynchronous reset in the third MD_WAIT cycle.
        ex_md_start = 1'b1;
        @(negedge clock);
        chk("mdr_c1", 32'(ctl), 32'(C_MD));
        step();
        ex_md_start = 1'b0;
        step();
        step();
        chk("mdr_c4", 32'(ctl), 32'(C_MD));
        #1;
        reset = 1'b0;
        #1;
        chk("mdr_rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("mdr_rst_cnt", 32'(stall_cnt), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clock);
            chk($sformatf("mdr_idle%0d", i), 32'(ctl), 32'(C_NONE));
        end

        // Saturation: 255 stall edges reach all-ones, one more stays there.
        step();
        ex_memread = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_rs1_used = 1'b1;
        repeat (255) @(posedge clock);
        @(negedge clock);
        chk("sat_reach", 32'(stall_cnt), 255);
        @(posedge clock);
        @(negedge clock);
        chk("sat_ctl", 32'(ctl), 32'(C_LU));
        chk("sat_hold", 32'(stall_cnt), 255);
        @(posedge clock);
        @(negedge clock);
        chk("sat_hold2", 32'(stall_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
